// File: rtl/mem_program_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_program_loader_pkg : shared types for the program-memory loader  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_program_loader_pkg;

  typedef logic [15:0] uword;

  localparam int LOADER_WORD_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_program_loader : byte-stream loader writing 16-bit instructions  |
// | into program memory; holds the core until a checksummed image lands. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_program_loader
  import mem_program_loader_pkg::*;
#(
  parameter uword BASE_ADDR = 16'h0000,
  parameter int   MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        prog_we,
  output uword        prog_addr,
  output uword        prog_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);
  localparam uword        ADDR_STEP   = 16'(LOADER_WORD_BYTES);

  loader_state_e r_state;
  loader_state_e w_state_next;

  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [7:0]  r_hi;
  logic [7:0]  r_xor;
  uword        r_next_addr;

  logic        w_accept;
  logic        w_start_load;
  logic [15:0] w_len;
  logic        w_last;

  assign w_accept = in_valid & in_ready;
  assign w_len    = {r_len_hi, in_data};
  // 17-bit compare so a full 16-bit count never aliases to zero
  assign w_last   = ({1'b0, word_count} + 17'd1) == {1'b0, r_len};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_load = 1'b0;
    in_ready     = 1'b0;
    cpu_hold     = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        cpu_hold = (r_state != DONE);
        done     = (r_state == DONE);
        error    = (r_state == ERROR);
        if (start) begin
          w_state_next = LEN_HI;
          w_start_load = 1'b1;
        end
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (w_accept) w_state_next = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (w_accept) begin
          if ({16'd0, w_len} > MAX_WORDS_U) w_state_next = ERROR;
          else if (w_len == 16'd0)          w_state_next = CHECK;
          else                              w_state_next = DATA_HI;
        end
      end
      DATA_HI: begin
        in_ready = 1'b1;
        if (w_accept) w_state_next = DATA_LO;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        if (w_accept) w_state_next = w_last ? CHECK : DATA_HI;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (w_accept) w_state_next = (in_data == r_xor) ? DONE : ERROR;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len_hi    <= 8'd0;
      r_len       <= 16'd0;
      r_hi        <= 8'd0;
      r_xor       <= 8'd0;
      r_next_addr <= BASE_ADDR;
      prog_we     <= 1'b0;
      prog_addr   <= BASE_ADDR;
      prog_wdata  <= 16'd0;
      word_count  <= 16'd0;
    end else begin
      prog_we <= 1'b0;
      if (w_start_load) begin
        r_xor       <= 8'd0;
        word_count  <= 16'd0;
        r_next_addr <= BASE_ADDR;
        prog_addr   <= BASE_ADDR;
      end
      // CHK itself is never folded into the running xor
      if (w_accept && r_state != CHECK) begin
        r_xor <= r_xor ^ in_data;
      end
      if (w_accept) begin
        case (r_state)
          LEN_HI:  r_len_hi <= in_data;
          LEN_LO:  r_len    <= w_len;
          DATA_HI: r_hi     <= in_data;
          DATA_LO: begin
            prog_we     <= 1'b1;
            prog_addr   <= r_next_addr;
            prog_wdata  <= {r_hi, in_data};
            r_next_addr <= r_next_addr + ADDR_STEP;
            word_count  <= word_count + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_program_loader : table-driven loads with a write scoreboard   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_program_loader;
  import mem_program_loader_pkg::*;

  localparam uword BASE = 16'h0000;
  localparam int   MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        prog_we;
  uword        prog_addr;
  uword        prog_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  mem_program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t sbq[$];

  typedef struct {
    logic [15:0]       len;
    logic [3:0][15:0]  w;
    bit                bad_chk;
    bit                gaps;
    logic              exp_done;
    logic              exp_err;
    logic [15:0]       exp_wc;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst && prog_we) begin
      if (sbq.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("wr_addr", {16'd0, prog_addr}, {16'd0, e.addr});
        check("wr_data", {16'd0, prog_wdata}, {16'd0, e.data});
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit mid_start);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      start = mid_start && (i == 0);
      @(negedge clk);
      start = 1'b0;
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
    check({tag, "_prog_we"},    {31'd0, prog_we},    32'd0);
    check({tag, "_prog_addr"},  {16'd0, prog_addr},  {16'd0, BASE});
    check({tag, "_prog_wdata"}, {16'd0, prog_wdata}, 32'd0);
    check({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd1);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_error"},      {31'd0, error},      32'd0);
    check({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
  endtask

  task automatic check_end(input string tag, input logic d, input logic e, input logic [15:0] wc);
    check({tag, "_done"},       {31'd0, done},       {31'd0, d});
    check({tag, "_error"},      {31'd0, error},      {31'd0, e});
    check({tag, "_cpu_hold"},   {31'd0, cpu_hold},   {31'd0, !d});
    check({tag, "_word_count"}, {16'd0, word_count}, {16'd0, wc});
    check({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
    check({tag, "_sb_empty"},   sbq.size(),          32'd0);
  endtask

  function automatic int pick_gap(input bit gaps);
    return gaps ? int'($urandom_range(0, 3)) : 0;
  endfunction

  task automatic do_load(input vec_t v, input string tag);
    logic [7:0] x;
    uword       a;
    x = 8'd0;
    a = BASE;
    pulse_start();
    send_byte(v.len[15:8], pick_gap(v.gaps), v.gaps);
    x ^= v.len[15:8];
    send_byte(v.len[7:0], pick_gap(v.gaps), v.gaps);
    x ^= v.len[7:0];
    if (v.len <= 16'(MAXW)) begin
      for (int i = 0; i < int'(v.len); i++) begin
        send_byte(v.w[i][15:8], pick_gap(v.gaps), v.gaps);
        x ^= v.w[i][15:8];
        sbq.push_back('{addr: a, data: v.w[i]});
        a = a + 16'd2;
        send_byte(v.w[i][7:0], pick_gap(v.gaps), v.gaps);
        x ^= v.w[i][7:0];
      end
      send_byte(v.bad_chk ? (x ^ 8'h01) : x, pick_gap(v.gaps), v.gaps);
    end
    check_end(tag, v.exp_done, v.exp_err, v.exp_wc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'd2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    tbl[1] = '{16'd2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2};
    tbl[2] = '{16'd0, {16'h0, 16'h0, 16'h0, 16'h0},       1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{16'd5, {16'h0, 16'h0, 16'h0, 16'h0},       1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[4] = '{16'd4, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
               1'b0, 1'b1, 1'b1, 1'b0, 16'd4};
    tbl[5] = '{16'd1, {16'h0, 16'h0, 16'h0, 16'($urandom)}, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[6] = '{16'd3, {16'h0, 16'($urandom), 16'($urandom), 16'($urandom)},
               1'b1, 1'b1, 1'b0, 1'b1, 16'd3};
    tbl[7] = '{16'h0100, {16'h0, 16'h0, 16'h0, 16'h0},    1'b0, 1'b0, 1'b0, 1'b1, 16'd0};

    // reset state
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // literal normal load with known checksum 0x42
    pulse_start();
    sbq.push_back('{addr: 16'h0000, data: 16'h1234});
    sbq.push_back('{addr: 16'h0002, data: 16'hABCD});
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'hCD, 0, 1'b0);
    send_byte(8'h42, 0, 1'b0);
    check_end("literal", 1'b1, 1'b0, 16'd2);

    for (int i = 0; i < 8; i++) begin
      do_load(tbl[i], $sformatf("vec%0d", i));
    end

    // start arriving together with the CHK byte: checksum result wins
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    sbq.push_back('{addr: 16'h0000, data: 16'h55AA});
    send_byte(8'h55, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    start = 1'b1;
    send_byte(8'hFE, 0, 1'b0);
    start = 1'b0;
    check_end("chk_start", 1'b1, 1'b0, 16'd1);
    @(negedge clk);
    check("chk_start_stay_done", {31'd0, done}, 32'd1);

    // reset mid-load after three data bytes
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    sbq.push_back('{addr: 16'h0000, data: 16'h1111});
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    check("midreset_sb_empty", sbq.size(), 32'd0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_load(tbl[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
